// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer in front of the ALU: fetches operands, strobes the
// ALU mode for one cycle, writes the result back and keeps the C/Z flags.
module alu_exec_ctrl #(
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic              instr_imm_en,
    input  logic [7:0]        instr_imm,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [7:0]        rf_rdata_a,
    input  logic [7:0]        rf_rdata_b,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [7:0]        alu_mode,
    output logic              alu_clr,
    input  logic [7:0]        alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [7:0]        rf_wdata,
    output logic              flag_c,
    output logic              flag_z,
    input  logic [1:0]        cond_sel,
    output logic              cond_true,
    output logic              done,
    output logic              illegal_op
);

    // ALU mode codes shared with the ALU
    localparam logic [7:0] ALU_NON = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_SUB = 8'h02;
    localparam logic [7:0] ALU_AND = 8'h03;
    localparam logic [7:0] ALU_OR  = 8'h04;
    localparam logic [7:0] ALU_XOR = 8'h05;
    localparam logic [7:0] ALU_NOT = 8'h06;
    localparam logic [7:0] ALU_SHL = 8'h07;
    localparam logic [7:0] ALU_SHR = 8'h08;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

    state_t            state_q, state_d;
    logic [7:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic              imm_en_q;
    logic [7:0]        imm_q;
    logic              op_legal;
    logic              accept;

    // Any code outside the defined ALU set (including ALU_NON) is dropped.
    assign op_legal = (op_q == ALU_ADD) || (op_q == ALU_SUB) || (op_q == ALU_AND) ||
                      (op_q == ALU_OR)  || (op_q == ALU_XOR) || (op_q == ALU_NOT) ||
                      (op_q == ALU_SHL) || (op_q == ALU_SHR);

    assign accept     = instr_valid && instr_ready;
    assign rf_raddr_a = rd_q;
    assign rf_raddr_b = rs_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = alu_out;

    // State, instruction latch, operand registers, flags and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= ALU_NON;
            rd_q       <= '0;
            rs_q       <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= 8'h00;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            done       <= (state_q == StWb);
            illegal_op <= (state_q == StRead) && !op_legal;
            if (accept) begin
                op_q     <= instr_op;
                rd_q     <= instr_rd;
                rs_q     <= instr_rs;
                imm_en_q <= instr_imm_en;
                imm_q    <= instr_imm;
            end
            if (state_q == StRead) begin
                alu_a <= rf_rdata_a;
                alu_b <= imm_en_q ? imm_q : rf_rdata_b;
            end
            if (state_q == StWb) begin
                flag_c <= alu_carry;
                flag_z <= alu_zero;
            end
        end
    end

    // Next state and per-state strobes; reset masks strobes combinationally
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        alu_mode    = ALU_NON;
        alu_clr     = 1'b1;
        rf_we       = 1'b0;
        case (state_q)
            StIdle: begin
                instr_ready = !reset;
                if (instr_valid && !reset) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = op_legal ? StExec : StIdle;
            end
            StExec: begin
                alu_mode = reset ? ALU_NON : op_q;
                alu_clr  = reset;
                state_d  = StWb;
            end
            StWb: begin
                // ALU holds the mode captured at the end of EXEC
                alu_clr = reset;
                rf_we   = !reset;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Jump condition from the architectural flags
    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            2'd0:    cond_true = 1'b1;
            2'd1:    cond_true = flag_z;
            2'd2:    cond_true = flag_c;
            default: cond_true = !flag_z;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl with a behavioural ALU and register file.
module tb_alu_exec_ctrl;

    localparam logic [7:0] NON = 8'h00, ADD = 8'h01, SUB = 8'h02, AND_ = 8'h03, OR_ = 8'h04;
    localparam logic [7:0] XOR_ = 8'h05, NOT_ = 8'h06, SHL = 8'h07, SHR = 8'h08;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr_op = 8'h00;
    logic [1:0] instr_rd = 2'd0;
    logic [1:0] instr_rs = 2'd0;
    logic       instr_imm_en = 1'b0;
    logic [7:0] instr_imm = 8'h00;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [7:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_mode, alu_out, rf_wdata;
    logic       alu_clr, alu_carry, alu_zero, rf_we, flag_c, flag_z, cond_true, done, illegal_op;
    logic [1:0] cond_sel = 2'd0;

    int checks = 0;
    int errors = 0;
    bit exp_c = 1'b0;
    bit exp_z = 1'b0;

    // Register file, ALU mode latch and bench preload port
    logic [7:0] rf [4];
    logic [7:0] alu_mode_q;
    logic       pre_we = 1'b0;
    logic [1:0] pre_addr = 2'd0;
    logic [7:0] pre_data = 8'h00;

    // Reference ALU: returns {carry, zero, result}
    function automatic logic [9:0] ref_alu(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            SUB:  begin r = a - b; c = (a < b); end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOT_: r = ~a;
            SHL:  r = {a[6:0], 1'b0};
            SHR:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: return 10'd0;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (pre_we) rf[pre_addr] <= pre_data;
        if (alu_clr) alu_mode_q <= NON;
        else if (alu_mode != NON) alu_mode_q <= alu_mode;
    end

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign {alu_carry, alu_zero, alu_out} = ref_alu(alu_mode_q, alu_a, alu_b);

    alu_exec_ctrl #(.REG_AW(2)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_clr(alu_clr),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_c(flag_c), .flag_z(flag_z), .cond_sel(cond_sel), .cond_true(cond_true),
        .done(done), .illegal_op(illegal_op)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Called and returns at a negative edge while the DUT is idle
    task automatic set_reg(input logic [1:0] addr, input logic [7:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_cond();
        logic exp;
        for (int s = 0; s < 4; s++) begin
            cond_sel = s[1:0];
            #1;
            exp = (s == 0) ? 1'b1 : (s == 1) ? exp_z : (s == 2) ? exp_c : !exp_z;
            checks++;
            if (cond_true !== exp) begin
                errors++;
                $display("FAIL cond sel=%0d: got %b want %b", s, cond_true, exp);
            end
        end
    endtask

    // Issue one instruction at the current negedge and check it cycle by cycle.
    // hold keeps instr_valid high with scrambled fields so the next call chains.
    task automatic run_instr(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic imm_en, input logic [7:0] imm, input bit hold);
        logic [7:0] a, b, res;
        logic       c, z, legal;
        a = rf[rd];
        b = imm_en ? imm : rf[rs];
        {c, z, res} = ref_alu(op, a, b);
        legal = (op >= ADD) && (op <= SHR);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
        instr_imm_en = imm_en; instr_imm = imm;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL accept ready: got %b want 1", instr_ready);
        end
        @(negedge clk);  // cycle 1: READ
        instr_valid = hold;
        instr_op = 8'($urandom); instr_rd = 2'($urandom); instr_rs = 2'($urandom);
        instr_imm_en = 1'($urandom); instr_imm = 8'($urandom);
        checks++;
        if ({instr_ready, rf_we, alu_mode, alu_clr, done} !== {1'b0, 1'b0, NON, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read cycle: ready=%b we=%b mode=%h clr=%b done=%b want 0 0 00 1 0",
                     instr_ready, rf_we, alu_mode, alu_clr, done);
        end
        @(negedge clk);  // cycle 2
        if (!legal) begin
            checks++;
            if ({illegal_op, alu_mode, rf_we, done, instr_ready} !== {1'b1, NON, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL illegal pulse: ill=%b mode=%h we=%b done=%b ready=%b want 1 00 0 0 1",
                         illegal_op, alu_mode, rf_we, done, instr_ready);
            end
            @(negedge clk);
            checks++;
            if ({illegal_op, alu_mode, rf_we, done, flag_c, flag_z} !==
                {1'b0, NON, 1'b0, 1'b0, exp_c, exp_z}) begin
                errors++;
                $display("FAIL illegal after: ill=%b mode=%h we=%b done=%b c=%b z=%b want 0 00 0 0 %b %b",
                         illegal_op, alu_mode, rf_we, done, flag_c, flag_z, exp_c, exp_z);
            end
            return;
        end
        checks++;
        if ({alu_mode, alu_a, alu_b, alu_clr, instr_ready, rf_we, illegal_op} !==
            {op, a, b, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL exec cycle: mode=%h a=%h b=%h clr=%b ready=%b we=%b ill=%b want %h %h %h 0 0 0 0",
                     alu_mode, alu_a, alu_b, alu_clr, instr_ready, rf_we, illegal_op, op, a, b);
        end
        @(negedge clk);  // cycle 3: WB
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, alu_mode, done, instr_ready, flag_c, flag_z} !==
            {1'b1, rd, res, NON, 1'b0, 1'b0, exp_c, exp_z}) begin
            errors++;
            $display("FAIL wb cycle: we=%b wa=%0d wd=%h mode=%h done=%b ready=%b c=%b z=%b want 1 %0d %h 00 0 0 %b %b",
                     rf_we, rf_waddr, rf_wdata, alu_mode, done, instr_ready, flag_c, flag_z,
                     rd, res, exp_c, exp_z);
        end
        @(negedge clk);  // cycle 4: retired
        exp_c = c; exp_z = z;
        checks++;
        if ({done, flag_c, flag_z, rf_we, instr_ready, rf[rd]} !==
            {1'b1, exp_c, exp_z, 1'b0, 1'b1, res}) begin
            errors++;
            $display("FAIL retire: done=%b c=%b z=%b we=%b ready=%b r%0d=%h want 1 %b %b 0 1 %h",
                     done, flag_c, flag_z, rf_we, instr_ready, rd, rf[rd], exp_c, exp_z, res);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({instr_ready, alu_a, alu_b, alu_mode, alu_clr, rf_we, flag_c, flag_z, done, illegal_op} !==
            {1'b0, 8'h00, 8'h00, NON, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset state: ready=%b a=%h b=%h mode=%h clr=%b we=%b c=%b z=%b done=%b ill=%b",
                     instr_ready, alu_a, alu_b, alu_mode, alu_clr, rf_we, flag_c, flag_z, done, illegal_op);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL ready after reset: got %b want 1", instr_ready);
        end
        for (int i = 0; i < 4; i++) set_reg(i[1:0], 8'h00);
    endtask

    task automatic test_add();
        set_reg(2'd0, 8'hF0); set_reg(2'd1, 8'h20);
        run_instr(ADD, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({rf[0], flag_c, flag_z} !== {8'h10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add result: r0=%h c=%b z=%b want 10 1 0", rf[0], flag_c, flag_z);
        end
    endtask

    task automatic test_sub_imm();
        set_reg(2'd2, 8'h33);
        run_instr(SUB, 2'd2, 2'd1, 1'b1, 8'h33, 1'b0);
        checks++;
        if ({rf[2], flag_c, flag_z} !== {8'h00, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sub result: r2=%h c=%b z=%b want 00 0 1", rf[2], flag_c, flag_z);
        end
        check_cond();
    endtask

    task automatic test_back_to_back();
        set_reg(2'd0, 8'h81); set_reg(2'd1, 8'hF0); set_reg(2'd2, 8'h3C);
        run_instr(AND_, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1);
        run_instr(OR_,  2'd2, 2'd1, 1'b0, 8'h00, 1'b1);
        run_instr(SHR,  2'd0, 2'd3, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({rf[0], rf[1], rf[2], flag_c} !== {8'h40, 8'h30, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL chain results: r0=%h r1=%h r2=%h c=%b want 40 30 3c 1", rf[0], rf[1], rf[2], flag_c);
        end
    endtask

    task automatic test_illegal();
        run_instr(NON, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0);
        run_instr(8'hA5, 2'd1, 2'd2, 1'b1, 8'h11, 1'b0);
        checks++;
        if (rf[1] !== 8'h30) begin
            errors++; $display("FAIL illegal wrote: r1=%h want 30", rf[1]);
        end
    endtask

    task automatic test_reset_mid();
        set_reg(2'd0, 8'h7F); set_reg(2'd1, 8'h01);
        instr_valid = 1'b1; instr_op = ADD; instr_rd = 2'd0; instr_rs = 2'd1; instr_imm_en = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);  // EXEC
        checks++;
        if (alu_mode !== ADD) begin
            errors++; $display("FAIL mid exec mode: got %h want %h", alu_mode, ADD);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rf_we, flag_c, flag_z, alu_clr, instr_ready, done, rf[0]} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F}) begin
            errors++;
            $display("FAIL mid reset: we=%b c=%b z=%b clr=%b ready=%b done=%b r0=%h want 0 0 0 1 0 0 7f",
                     rf_we, flag_c, flag_z, alu_clr, instr_ready, done, rf[0]);
        end
        reset = 1'b0;
        exp_c = 1'b0; exp_z = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready, rf_we, done, rf[0]} !== {1'b1, 1'b0, 1'b0, 8'h7F}) begin
            errors++;
            $display("FAIL after mid reset: ready=%b we=%b done=%b r0=%h want 1 0 0 7f",
                     instr_ready, rf_we, done, rf[0]);
        end
        run_instr(ADD, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_shl_same_reg();
        set_reg(2'd3, 8'h80);
        run_instr(SHL, 2'd3, 2'd3, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks++;
        if ({done, rf[3], flag_z, flag_c} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL shl: done=%b r3=%h z=%b c=%b want 0 00 1 0", done, rf[3], flag_z, flag_c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(8'($urandom_range(0, 11)), 2'($urandom), 2'($urandom), 1'($urandom),
                      8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            check_cond();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_imm();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_shl_same_reg();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
